// File: rtl/lcd_timing_pkg.sv
// Shared timing definitions for the ST7920 LCD pacing logic.
// Holds the wait-timer state encoding and 50 MHz divisor / wait constants that
// the LCD controller uses when programming lcd_tick_generator.
package lcd_timing_pkg;

  // Wait timer states.
  typedef enum logic {
    StIdle,
    StCount
  } wait_state_e;

  // Divisors for a 50 MHz system clock (tick period = div + 1 cycles).
  localparam int unsigned LCD_DIV_1US       = 49;
  localparam int unsigned LCD_DIV_72US      = 3599;

  // Wait lengths in microseconds, for use with a 1 us tick.
  localparam int unsigned LCD_WAIT_CLEAR_US = 1600;
  localparam int unsigned LCD_WAIT_CMD_US   = 72;

endpackage

// File: rtl/lcd_wait_timer.sv
// One-shot wait timer counting divider ticks.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset; aborts a wait without a done pulse
//   tick_i   registered tick strobe from the divider
//   start_i  request a wait of ticks_i ticks (ignored while busy)
//   ticks_i  number of ticks to wait; zero completes on the next edge
//   busy_o   high while a wait is in progress
//   done_o   one-cycle pulse when the wait completes
module lcd_wait_timer
  import lcd_timing_pkg::*;
#(
  parameter int unsigned WaitWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tick_i,
  input  logic                 start_i,
  input  logic [WaitWidth-1:0] ticks_i,
  output logic                 busy_o,
  output logic                 done_o
);

  wait_state_e          state_q, state_d;
  logic [WaitWidth-1:0] remaining_q, remaining_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (ticks_i != '0) begin
            remaining_d = ticks_i;
            state_d     = StCount;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StCount: begin
        // start_i is deliberately not looked at here: no restart or extend.
        if (tick_i) begin
          if (remaining_q == WaitWidth'(1)) begin
            remaining_d = '0;
            done_d      = 1'b1;
            state_d     = StIdle;
          end else begin
            remaining_d = remaining_q - WaitWidth'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // Busy follows the registered state, so it rises and falls on the same
  // edges as the state transitions.
  assign busy_o = (state_q == StCount);
  assign done_o = done_q;

endmodule

// File: rtl/lcd_tick_generator.sv
// Runtime-programmable tick divider for ST7920 command pacing, with a one-shot
// wait timer so the LCD controller can wait a number of ticks.
// Ports:
//   clk         system clock (50 MHz on board)
//   reset       synchronous active-high reset
//   enable      divider runs when high, holds when low
//   div_load    one-cycle strobe: load div_value and restart the count
//   div_value   new divisor, tick period = div_value + 1 cycles
//   tick        registered one-cycle strobe per divider period
//   clk_div     registered, toggles on every tick
//   wait_start  request a wait of wait_ticks ticks
//   wait_ticks  number of ticks to wait
//   wait_busy   high while a wait is in progress
//   wait_done   one-cycle pulse at the end of a wait
module lcd_tick_generator
  import lcd_timing_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 2047,
  parameter int unsigned WAIT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  div_load,
  input  logic [CNT_WIDTH-1:0]  div_value,
  output logic                  tick,
  output logic                  clk_div,
  input  logic                  wait_start,
  input  logic [WAIT_WIDTH-1:0] wait_ticks,
  output logic                  wait_busy,
  output logic                  wait_done
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic                 tick_q, tick_d;
  logic                 clk_div_q, clk_div_d;

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    clk_div_d = clk_div_q;
    // A load wins over terminal count and works even while disabled.
    if (div_load) begin
      div_d = div_value;
      cnt_d = '0;
    end else if (enable) begin
      // Equality compare is safe: loads always zero the counter, so it can
      // never be above div_q.
      if (cnt_q == div_q) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_div_d = ~clk_div_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= CNT_WIDTH'(DEFAULT_DIV);
      tick_q    <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign tick    = tick_q;
  assign clk_div = clk_div_q;

  // The timer sees the registered tick, so a tick issued on the start edge is
  // only counted on the following cycle, once the timer is in StCount.
  lcd_wait_timer #(
    .WaitWidth (WAIT_WIDTH)
  ) u_wait_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_i  (tick_q),
    .start_i (wait_start),
    .ticks_i (wait_ticks),
    .busy_o  (wait_busy),
    .done_o  (wait_done)
  );

endmodule

// File: tb/tb_lcd_tick_generator.sv
module tb_lcd_tick_generator;

  localparam int unsigned Def = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_value = '0;
  logic        tick, clk_div;
  logic        wait_start = 1'b0;
  logic [15:0] wait_ticks = '0;
  logic        wait_busy, wait_done;

  lcd_tick_generator #(
    .CNT_WIDTH   (16),
    .DEFAULT_DIV (Def),
    .WAIT_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .div_load   (div_load),
    .div_value  (div_value),
    .tick       (tick),
    .clk_div    (clk_div),
    .wait_start (wait_start),
    .wait_ticks (wait_ticks),
    .wait_busy  (wait_busy),
    .wait_done  (wait_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural reference, written from the block's timing description.
  logic [15:0] m_cnt = '0, m_div = Def[15:0], m_rem = '0;
  bit          m_tick = 0, m_clkdiv = 0, m_busy = 0, m_done = 0;

  typedef struct packed {
    bit tk; bit cd; bit bz; bit dn;
  } exp_t;
  exp_t sb_q[$];

  task automatic model_step(input bit r, input bit e, input bit l, input logic [15:0] dv,
                            input bit w, input logic [15:0] wt);
    bit tick_seen;
    tick_seen = m_tick;
    if (r) begin
      m_cnt = 0; m_div = Def[15:0]; m_tick = 0; m_clkdiv = 0;
      m_rem = 0; m_busy = 0; m_done = 0;
      return;
    end
    if (l) begin
      m_div = dv; m_cnt = 0; m_tick = 0;
    end else if (!e) begin
      m_tick = 0;
    end else if (m_cnt == m_div) begin
      m_cnt = 0; m_tick = 1; m_clkdiv = !m_clkdiv;
    end else begin
      m_cnt = m_cnt + 1; m_tick = 0;
    end
    m_done = 0;
    if (!m_busy) begin
      if (w) begin
        if (wt != 0) begin m_rem = wt; m_busy = 1; end
        else m_done = 1;
      end
    end else if (tick_seen) begin
      if (m_rem == 1) begin m_done = 1; m_busy = 0; m_rem = 0; end
      else m_rem = m_rem - 1;
    end
  endtask

  // Drive one cycle, push the expected result, then compare after the edge.
  task automatic cycle(input bit r, input bit e, input bit l, input logic [15:0] dv,
                       input bit w, input logic [15:0] wt);
    exp_t ex;
    reset = r; enable = e; div_load = l; div_value = dv; wait_start = w; wait_ticks = wt;
    model_step(r, e, l, dv, w, wt);
    sb_q.push_back('{tk: m_tick, cd: m_clkdiv, bz: m_busy, dn: m_done});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      ex = sb_q.pop_front();
      chk("sb_tick", int'(tick), int'(ex.tk));
      chk("sb_clk_div", int'(clk_div), int'(ex.cd));
      chk("sb_wait_busy", int'(wait_busy), int'(ex.bz));
      chk("sb_wait_done", int'(wait_done), int'(ex.dn));
    end
  endtask

  typedef struct {
    bit rst; bit en; bit ld; logic [15:0] dv; bit ws; logic [15:0] wt;
    bit tk; bit cd; bit bz; bit dn;
  } vec_t;

  function automatic vec_t mk(bit rst, bit en, bit ld, logic [15:0] dv, bit ws,
                              logic [15:0] wt, bit tk, bit cd, bit bz, bit dn);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.dv = dv; v.ws = ws; v.wt = wt;
    v.tk = tk; v.cd = cd; v.bz = bz; v.dn = dn;
    return v;
  endfunction

  // Run a wait after loading divisor 3; latency is edges from start to done.
  task automatic run_wait(input logic [15:0] wt, input int pause_at, input int restart_at,
                          output int lat, output int busy_start, output int busy_done);
    bit e;
    cycle(0, 1, 1, 16'd3, 0, '0);
    cycle(0, 1, 0, '0, 1, wt);
    busy_start = int'(wait_busy);
    lat = -1;
    busy_done = -1;
    for (int k = 1; k <= 200; k++) begin
      e = !(k >= pause_at && k < pause_at + 10);
      cycle(0, e, 0, '0, (k == restart_at), 16'd1);
      if (wait_done) begin
        lat = k;
        busy_done = int'(wait_busy);
        break;
      end
    end
  endtask

  vec_t tbl[16];

  initial begin
    int lat, bs, bd, cnt_a, cnt_b;

    // Reset, then free run with divisor 3: ticks at edges 4, 8, 12.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Zero-length wait: done on the next edge, busy never set.
    tbl[14] = mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].dv, tbl[i].ws, tbl[i].wt);
      chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].tk));
      chk($sformatf("tbl%0d_clk_div", i), int'(clk_div), int'(tbl[i].cd));
      chk($sformatf("tbl%0d_busy", i), int'(wait_busy), int'(tbl[i].bz));
      chk($sformatf("tbl%0d_done", i), int'(wait_done), int'(tbl[i].dn));
    end

    // Divisor 0: tick every cycle from the second edge after the load.
    cycle(0, 1, 1, 16'd0, 0, '0);
    chk("div0_load_edge_tick", int'(tick), 0);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 6; k++) begin
      bit prev;
      prev = clk_div;
      cycle(0, 1, 0, '0, 0, '0);
      cnt_a += int'(tick);
      cnt_b += int'(clk_div != prev);
    end
    chk("div0_tick_count", cnt_a, 6);
    chk("div0_toggle_count", cnt_b, 6);

    // Two-tick wait with divisor 3.
    run_wait(16'd2, -100, -1, lat, bs, bd);
    chk("wait2_busy_after_start", bs, 1);
    chk("wait2_latency", lat, 8);
    chk("wait2_busy_at_done", bd, 0);
    cycle(0, 1, 0, '0, 0, '0);
    chk("wait2_done_one_cycle", int'(wait_done), 0);

    // Three-tick wait: baseline, with a 10-cycle pause, and with a restart attempt.
    run_wait(16'd3, -100, -1, lat, bs, bd);
    chk("wait3_latency", lat, 12);
    run_wait(16'd3, 2, -1, lat, bs, bd);
    chk("wait3_pause_latency", lat, 22);
    chk("wait3_pause_busy_at_done", bd, 0);
    run_wait(16'd3, -100, 5, lat, bs, bd);
    chk("wait3_restart_ignored", lat, 12);

    // Reset in the middle of a wait: aborted, no done pulse afterwards.
    cycle(0, 1, 1, 16'd3, 0, '0);
    cycle(0, 1, 0, '0, 1, 16'd3);
    for (int k = 0; k < 5; k++) cycle(0, 1, 0, '0, 0, '0);
    chk("midwait_busy_before_reset", int'(wait_busy), 1);
    cycle(1, 1, 0, '0, 0, '0);
    chk("midwait_reset_busy", int'(wait_busy), 0);
    chk("midwait_reset_tick", int'(tick), 0);
    chk("midwait_reset_clk_div", int'(clk_div), 0);
    cnt_a = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(0, 1, 0, '0, 0, '0);
      cnt_a += int'(wait_done);
    end
    chk("midwait_no_done", cnt_a, 0);

    // Reset exactly at terminal count with divisor 5; divisor returns to default.
    cycle(0, 1, 1, 16'd5, 0, '0);
    for (int k = 0; k < 20 && m_cnt != m_div; k++) cycle(0, 1, 0, '0, 0, '0);
    chk("tc_reached", int'(m_cnt == m_div), 1);
    cycle(1, 1, 0, '0, 1, 16'd2);
    chk("tc_reset_tick", int'(tick), 0);
    chk("tc_reset_clk_div", int'(clk_div), 0);
    chk("tc_reset_busy", int'(wait_busy), 0);
    chk("tc_reset_done", int'(wait_done), 0);
    cnt_a = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, '0, 0, '0);
      cnt_a += int'(tick);
    end
    chk("tc_default_div_tick_count", cnt_a, 1);
    chk("tc_default_div_tick_edge4", int'(tick), 1);
    chk("tc_default_div_clk_div", int'(clk_div), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_tick_generator.md
Name: lcd_tick_generator

Overview:
- Parametrised successor of the LCD clock divider, driving ST7920 12864 command pacing.
- Divisor is runtime-loadable and the divider can be paused.
- Outputs a one-cycle `tick` strobe plus a 50% duty `clk_div`.
- Adds a one-shot wait timer (start/busy/done) so the LCD controller FSM can wait N ticks, e.g. 72 us per command or 1.6 ms for clear.

Parameters:
- CNT_WIDTH, 16: width of divider counter and divisor register.
- DEFAULT_DIV, 2047: divisor loaded at reset; tick period = DEFAULT_DIV+1 clk cycles.
- WAIT_WIDTH, 16: width of wait tick count.

Ports:
- clk  in  1  system clock (50 MHz on board).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  divider runs when high; holds state when low.
- div_load  in  1  one-cycle strobe: load div_value.
- div_value  in  CNT_WIDTH  new divisor, period = div_value+1 cycles.
- tick  out  1  registered one-cycle strobe each divider period.
- clk_div  out  1  registered, toggles on every tick.
- wait_start  in  1  request a wait of wait_ticks ticks.
- wait_ticks  in  WAIT_WIDTH  number of ticks to wait.
- wait_busy  out  1  high while a wait is in progress.
- wait_done  out  1  registered one-cycle pulse at end of wait.

Behaviour:
- Reset (sync, active-high):
  - counter=0, div_reg=DEFAULT_DIV.
  - tick=0, clk_div=0.
  - FSM=IDLE, remaining=0, wait_busy=0, wait_done=0.
  - Reset overrides all other inputs, including mid-wait: the wait is aborted and no done pulse is issued.
- Divider, enable=1, no load:
  - If counter==div_reg: counter<=0, tick<=1, clk_div<=~clk_div.
  - Else: counter<=counter+1, tick<=0.
  - First tick after reset with DEFAULT_DIV=D is visible D+1 rising edges after reset release, then every D+1 cycles.
- enable=0: counter and clk_div hold; tick<=0.
- div_load:
  - div_reg<=div_value, counter<=0, tick<=0 that cycle; clk_div holds.
  - Takes priority over the terminal-count event in the same cycle.
  - Acts regardless of enable.
- div_value=0: tick high every enabled cycle; clk_div toggles every cycle (clk/2).
- Counter never exceeds div_reg. No wrap beyond div_reg is possible since the compare is equality and a load resets the counter.
- Wait FSM states: IDLE, COUNT.
  - IDLE + wait_start, wait_ticks>0: remaining<=wait_ticks, go to COUNT, wait_busy<=1 on the next edge.
  - IDLE + wait_start, wait_ticks==0: wait_done<=1 on the next edge; stay IDLE; wait_busy stays 0.
  - COUNT: each cycle with tick==1 decrements remaining.
    - Ticks counted are only those sampled strictly after the start cycle.
    - When tick==1 and remaining==1: wait_done<=1, wait_busy<=0, go to IDLE.
  - wait_start while in COUNT: ignored (no restart, no extend).
  - wait_start in the same cycle the wait completes: ignored, because FSM is still COUNT.
  - enable=0 during COUNT: no ticks arrive, so the wait stalls with wait_busy held.
  - div_load during COUNT: allowed; the counter restart lengthens the current tick interval.
  - wait_done is exactly one cycle; otherwise 0.

Decomposition:
- Package lcd_timing_pkg holds:
  - wait FSM state enum {IDLE, COUNT}.
  - Constants at 50 MHz: LCD_DIV_1US=49, LCD_DIV_72US=3599, LCD_WAIT_CLEAR_US=1600, LCD_WAIT_CMD_US=72.
- One natural sub-module, lcd_wait_timer: wait FSM + remaining counter, consuming the tick strobe.
- The divider stays in the top.

Test Plan:
- DEFAULT_DIV=3, enable=1 from reset release → tick high at edges 4, 8, 12; clk_div=1, 0, 1 after those edges.
- Load div_value=0 mid-run → tick high every cycle from the second edge after load; clk_div toggles every cycle.
- Divisor 3, wait_start with wait_ticks=2 → wait_busy high next edge; wait_done pulses one cycle after the second post-start tick; wait_busy low in that same cycle.
- wait_ticks=0 → wait_done pulses on the next edge; wait_busy never high.
- During a 3-tick wait:
  - enable=0 for 10 cycles → no ticks; busy held; done delayed by exactly 10 cycles.
  - Second wait_start mid-wait → ignored.
- Reset asserted mid-wait and at terminal count → all outputs 0 next edge; div_reg=DEFAULT_DIV; no wait_done pulse.
